pe_col_accum: RTL
=================

// Module: pe_col_accum
// PURPOSE
//  Column partial-sum accumulator sitting directly downstream of a column of PEs.
//  - Each beat sums the ROWS 16-bit PE products (mul_out) through a registered adder tree.
//  - Accumulates acc_len beats (one output pixel's reduction over channels/kernel taps).
//  - Presents the final psum on a valid/ready output port to the psum writeback stage.
// PARAMETERS
//  ROWS   4   number of PEs per column (products summed per beat); power of 2, >=2
//  MUL_W  16  width of each PE product (unsigned 8x8)
//  ACC_W  32  accumulator / psum_out width; must be >= MUL_W+$clog2(ROWS)
//  CNT_W  8   width of acc_len and beat counter
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  start      in   1            1-cycle pulse: begin new accumulation (honoured in IDLE only)
//  acc_len    in   CNT_W        beats to accumulate; sampled on accepted start; 0 treated as 1
//  in_valid   in   1            mul_in carries valid products this cycle
//  in_ready   out  1            accumulator accepts a beat; feeds PE_en/PE_stall gating upstream
//  mul_in     in   ROWS*MUL_W   packed PE products, row r at [r*MUL_W +: MUL_W]
//  out_valid  out  1            psum_out valid
//  out_ready  in   1            downstream accepts psum_out
//  psum_out   out  ACC_W        accumulated result, unsigned
//  busy       out  1            high in any state other than IDLE
//  ovf        out  1            sticky overflow flag for current result (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0, out_valid=0, busy=0, ovf=0, psum_out=0; tree reg, counter, acc=0.
//  - Reset mid-operation aborts immediately; partial accumulation discarded, no output emitted.
//  - FSM states: IDLE, ACCUM, DRAIN, OUT.
//    IDLE : start=1 -> latch len=(acc_len==0?1:acc_len), cnt=0, clear acc and ovf -> ACCUM.
//    ACCUM: in_ready=1. Beat accepted when in_valid&in_ready; cnt++. Accepted beat with
//           cnt==len-1 -> DRAIN (in_ready low from next cycle). in_valid=0 just holds state.
//    DRAIN: in_ready=0; waits one cycle for last tree result to enter acc -> OUT.
//    OUT  : out_valid=1, psum_out=acc held stable; out_valid&out_ready -> IDLE next cycle.
//  - start outside IDLE is ignored (no relatch, no restart); start and out handshake in
//    same OUT cycle: handshake completes, start ignored.
//  - Pipeline: stage1 registers s1 = sum of ROWS products (width MUL_W+$clog2(ROWS)), s1_vld.
//    stage2: s1_vld -> acc <= acc + zero-extended s1. First beat lands in cleared acc.
//  - Latency: last beat accepted at cycle t -> out_valid=1 at cycle t+2 (s1 at t+1, acc at t+2 edge).
//  - Throughput: 1 beat/cycle in ACCUM; min turnaround len+3 cycles per result incl. OUT and IDLE.
//  - mul_in ignored whenever in_ready=0 or in_valid=0; no beat is dropped or double-counted.
//  - Arithmetic unsigned; products zero-extended to ACC_W before accumulation.
// CONFIGURATION
//  Macro PE_COL_ACCUM_SAT_EN:
//   defined    : acc saturates at 2^ACC_W-1; any add that would exceed sets ovf=1 (sticky
//                until next accepted start); psum_out = 2^ACC_W-1.
//   undefined  : acc wraps modulo 2^ACC_W; ovf tied 0; no saturation logic synthesised.
// TESTING  (ROWS=4, MUL_W=16, ACC_W=32 unless stated)
//  1 Reset: assert rst_n=0 mid-ACCUM -> all outputs 0, state IDLE; no out_valid after release.
//  2 Basic: start, acc_len=3, 3 beats {100,200,300,400} back-to-back -> psum_out=3000,
//    out_valid exactly 2 cycles after 3rd beat, in_ready low from DRAIN onward.
//  3 Bubbles/back-pressure: acc_len=4, in_valid toggled 1,0,1,0,... products {1,2,3,4};
//    out_ready held 0 for 5 cycles -> psum_out=40 stable, out_valid held until accept.
//  4 acc_len=0 and acc_len=1 with products {65535 x4} -> psum_out=262140 after one beat.
//  5 start pulsed during ACCUM and OUT -> ignored; result unchanged, then fresh start works.
//  6 ACC_W=18, all products 65535, acc_len=2: with PE_COL_ACCUM_SAT_EN psum_out=262143,
//    ovf=1; without it psum_out=(524280 mod 2^18)=262136, ovf=0.

Source files
------------

// File: rtl/pe_col_accum.sv
// pe_col_accum: column psum accumulator; registered adder tree feeding a beat accumulator with a valid/ready result port.
// Define PE_COL_ACCUM_SAT_EN to saturate the accumulator and report a sticky ovf; otherwise it wraps and ovf is tied 0.
module pe_col_accum #(
  parameter int ROWS  = 4,
  parameter int MUL_W = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      acc_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*MUL_W-1:0] mul_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      psum_out,
  output logic                  busy,
  output logic                  ovf
);
  localparam int SW = MUL_W + $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [SW-1:0] s1_q, s1_d, tree;
  logic s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic beat, go;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != IDLE;
  assign psum_out  = acc_q;
  assign beat      = in_valid & in_ready;
  assign go        = start & (state_q == IDLE);
  always_comb begin
    tree = '0;
    for (int r = 0; r < ROWS; r++) tree = tree + SW'(mul_in[r*MUL_W +: MUL_W]);
  end
`ifdef PE_COL_ACCUM_SAT_EN
  logic [ACC_W:0] sum;
  logic ovf_q, ovf_d;
  assign sum    = {1'b0, acc_q} + (ACC_W+1)'(s1_q);
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign ovf_d  = go ? 1'b0 : ovf_q | (s1_vld_q & sum[ACC_W]);
  assign ovf    = ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
`else
  assign acc_nx = acc_q + ACC_W'(s1_q);
  assign ovf    = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    s1_vld_d = beat;
    s1_d     = beat ? tree : s1_q;
    acc_d    = go ? '0 : s1_vld_q ? acc_nx : acc_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        len_d   = acc_len == '0 ? CNT_W'(1) : acc_len;
        cnt_d   = '0;
      end
      ACCUM: if (beat) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == len_q - CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      acc_q    <= acc_d;
    end
endmodule
